ascon_round_sequencer: RTL and testbench
========================================

Name: ascon_round_sequencer

Overview:
- Control-side counterpart to the permutation datapath; drives the round index consumed by the constant-addition layer.
- Accepts a permutation request with a round count and issues round indices 12-nr ... 11 on consecutive cycles.
- Generates the state-register enable and input-select strobes, then signals completion.
- Sits between the Ascon mode FSM (requester) and the permutation round datapath (pc/ps/pl layers plus state register).

Parameters:
- MAX_ROUNDS, 12, total round constants available; the index of the last round is always MAX_ROUNDS-1.
- ROUND_W, 4, width of round index and round count buses.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- i_start  input  1  permutation request; accepted only when o_ready=1.
- i_nb_rounds  input  ROUND_W  requested round count, sampled on accept; legal range 1..MAX_ROUNDS.
- i_hold  input  1  stall; freezes the sequencer while in RUN.
- o_ready  output  1  high in IDLE only.
- o_round  output  ROUND_W  current round index for the constant adder.
- o_round_valid  output  1  state-register enable; high in RUN when i_hold=0.
- o_sel_input  output  1  high during the first round cycle; selects the external state into the datapath.
- o_busy  output  1  high in RUN and DONE.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  one-cycle pulse when a request with an illegal count is rejected.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, o_round=0, o_round_valid=0, o_sel_input=0, o_busy=0, o_done=0, o_err=0. o_ready=1 from the first cycle after reset.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs except o_round_valid, which is gated by i_hold.
- IDLE, i_start=1, 1 <= i_nb_rounds <= MAX_ROUNDS:
  - o_round <= MAX_ROUNDS - i_nb_rounds.
  - first-round flag set.
  - state <= RUN.
- IDLE, i_start=1, i_nb_rounds=0 or > MAX_ROUNDS:
  - o_err=1 for exactly the next cycle.
  - stays IDLE; o_round unchanged.
- RUN, i_hold=0: o_round_valid=1. o_sel_input=1 only while the first-round flag is set; the flag clears on this edge.
  - If o_round = MAX_ROUNDS-1: state <= DONE, o_round holds.
  - Otherwise: o_round <= o_round + 1.
- RUN, i_hold=1: o_round_valid=0. o_round, first-round flag and state all hold. o_sel_input stays asserted if the first round has not yet executed.
- DONE: o_done=1 for one cycle; state <= IDLE; o_round <= 0.
- Latency: from the accept edge, the first round cycle is the next cycle. With no holds, nr RUN cycles follow, then o_done on cycle nr+1.
- i_start outside IDLE is ignored, with no error and no queuing.
- i_hold in IDLE or DONE has no effect.
- reset_n low in any state returns to IDLE on that edge; the in-flight permutation is discarded and o_done is not issued.
- o_round never exceeds MAX_ROUNDS-1; there is no wrap-around.

Test Plan:
- Reset, then i_start with i_nb_rounds=12 -> o_round 0,1,...,11 over 12 cycles with o_round_valid=1; o_sel_input high on the round-0 cycle only; o_done on cycle 13; o_ready returns to 1.
- i_nb_rounds=6 -> o_round 6..11 (6 cycles); o_done 7 cycles after accept. Repeat with 8 -> indices 4..11.
- i_nb_rounds=0, then 13 -> o_err one-cycle pulse each time; o_ready stays 1; o_round_valid never asserts.
- 12-round run with i_hold=1 for 3 cycles at o_round=5 -> o_round_valid=0 and o_round=5 held for 3 cycles; o_done delayed by 3 cycles. Hold on the first cycle -> o_sel_input remains high until the first unheld cycle.
- i_start pulsed at round 3 of an 8-round run -> ignored; the sequence completes unchanged with a single o_done.
- reset_n=0 at o_round=7 -> IDLE next cycle, o_round=0, no o_done. A subsequent 12-round request behaves normally.

Source files
------------

// File: rtl/ascon_round_sequencer.sv
// Round-index sequencer for the Ascon permutation: issues indices MAX_ROUNDS-nr .. MAX_ROUNDS-1,
// one per unheld cycle, plus state-register enable / input-select strobes and a done pulse.
module ascon_round_sequencer #(
  parameter int MAX_ROUNDS = 12,
  parameter int ROUND_W    = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [ROUND_W-1:0] i_nb_rounds,
  input  logic               i_hold,
  output logic               o_ready,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_round_valid,
  output logic               o_sel_input,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ROUND_W-1:0] MAX_R  = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] LAST_R = ROUND_W'(MAX_ROUNDS - 1);

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               first_q, first_d;
  logic               err_q, err_d;
  logic               nb_legal;

  assign nb_legal = (i_nb_rounds != '0) && (i_nb_rounds <= MAX_R);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    first_d = first_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (nb_legal) begin
            round_d = MAX_R - i_nb_rounds;
            first_d = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // A held cycle freezes everything, including the pending first-round select.
        if (!i_hold) begin
          first_d = 1'b0;
          if (round_q == LAST_R) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        round_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        round_d = '0;
        first_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_round       = round_q;
  assign o_round_valid = (state_q == S_RUN) && !i_hold;
  assign o_sel_input   = (state_q == S_RUN) && first_q;
  assign o_busy        = (state_q == S_RUN) || (state_q == S_DONE);
  assign o_done        = (state_q == S_DONE);
  assign o_err         = err_q;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Self-checking bench for ascon_round_sequencer: expected round indices are queued on accept
// and popped on every cycle the DUT reports a valid round.
module tb_ascon_round_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       i_start;
  logic [3:0] i_nb_rounds;
  logic       i_hold;
  logic       o_ready;
  logic [3:0] o_round;
  logic       o_round_valid;
  logic       o_sel_input;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int n_chk  = 0;
  int n_fail = 0;
  int rnd_q[$];

  ascon_round_sequencer #(.MAX_ROUNDS(12), .ROUND_W(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_nb_rounds   (i_nb_rounds),
    .i_hold        (i_hold),
    .o_ready       (o_ready),
    .o_round       (o_round),
    .o_round_valid (o_round_valid),
    .o_sel_input   (o_sel_input),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One permutation: optional hold of hold_len cycles when expected round == hold_rnd,
  // optional spurious i_start when expected round == poke_rnd.
  task automatic run_perm(input int nr, input int hold_rnd, input int hold_len, input int poke_rnd);
    int  cyc;
    int  holds_left;
    int  dones;
    bit  first;
    bit  poked;
    @(negedge clock);
    i_start     = 1'b1;
    i_nb_rounds = 4'(nr);
    #1;
    chk("ready_at_accept", o_ready, 1);
    rnd_q.delete();
    for (int r = 12 - nr; r < 12; r++) rnd_q.push_back(r);
    @(negedge clock);
    cyc        = 1;
    holds_left = hold_len;
    dones      = 0;
    first      = 1'b1;
    poked      = 1'b0;
    while (cyc <= nr + hold_len + 2) begin
      i_start = 1'b0;
      i_hold  = 1'b0;
      if (rnd_q.size() > 0 && rnd_q[0] == hold_rnd && holds_left > 0) i_hold = 1'b1;
      if (rnd_q.size() > 0 && rnd_q[0] == poke_rnd && !poked) begin
        i_start     = 1'b1;
        i_nb_rounds = 4'd12;
        poked       = 1'b1;
      end
      #1;
      chk("err_quiet", o_err, 0);
      if (rnd_q.size() > 0) begin
        chk("round_valid", o_round_valid, !i_hold);
        chk("round_idx", o_round, rnd_q[0]);
        chk("sel_input", o_sel_input, first);
        chk("busy_run", o_busy, 1);
        chk("ready_run", o_ready, 0);
        chk("done_early", o_done, 0);
        if (!i_hold) begin
          void'(rnd_q.pop_front());
          first = 1'b0;
        end else begin
          holds_left--;
        end
      end else if (dones == 0) begin
        chk("done_pulse", o_done, 1);
        chk("done_cycle", cyc, nr + hold_len + 1);
        chk("done_valid", o_round_valid, 0);
        chk("busy_done", o_busy, 1);
        dones = 1;
      end else begin
        chk("done_once", o_done, 0);
        chk("ready_after", o_ready, 1);
        chk("round_cleared", o_round, 0);
        chk("busy_after", o_busy, 0);
      end
      @(negedge clock);
      cyc++;
    end
    i_start = 1'b0;
    i_hold  = 1'b0;
    if (dones == 0) chk("done_seen", 0, 1);
  endtask

  task automatic bad_req(input int nb);
    @(negedge clock);
    i_start     = 1'b1;
    i_nb_rounds = 4'(nb);
    #1;
    chk("ready_bad", o_ready, 1);
    @(negedge clock);
    i_start = 1'b0;
    #1;
    chk("err_pulse", o_err, 1);
    chk("err_ready", o_ready, 1);
    chk("err_valid", o_round_valid, 0);
    chk("err_round", o_round, 0);
    @(negedge clock);
    #1;
    chk("err_one_cycle", o_err, 0);
    chk("err_valid2", o_round_valid, 0);
    chk("err_busy", o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    reset_n     = 1'b0;
    i_start     = 1'b0;
    i_nb_rounds = '0;
    i_hold      = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_round", o_round, 0);
    chk("rst_valid", o_round_valid, 0);
    chk("rst_sel", o_sel_input, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    reset_n = 1'b1;

    run_perm(12, -1, 0, -1);
    run_perm(6, -1, 0, -1);
    run_perm(8, -1, 0, -1);
    run_perm(1, -1, 0, -1);
    bad_req(0);
    bad_req(13);
    bad_req(15);
    run_perm(12, 5, 3, -1);
    run_perm(12, 0, 2, -1);
    run_perm(8, -1, 0, 7);

    // Reset in the middle of a 12-round run at round 7.
    @(negedge clock);
    i_start     = 1'b1;
    i_nb_rounds = 4'd12;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      i_start = 1'b0;
    end
    #1;
    chk("pre_reset_round", o_round, 7);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("abort_round", o_round, 0);
    chk("abort_ready", o_ready, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_sel", o_sel_input, 0);
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1;
      if (o_done || o_round_valid) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_perm(12, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
